fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin write-port arbiter that shares one FIFO (the `fifo_ctrl` plus register file pair) among `NumReq` producers. It grants one producer at a time, forwards that producer's data to the FIFO write port, and stalls the producer while the FIFO reports full. An optional burst lock keeps a grant for up to `MaxBurst` accepted words to reduce switching.

## Interface
- `NumReq`, default 4: number of requesters; must be ≥2.
- `WordLength`, default 8: data width per requester.
- `MaxBurst`, default 4: words accepted per grant before a forced re-arbitration; must be ≥1. Used only with the burst feature.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  NumReq  per-requester write request; level, held while data is pending.
- `data_i`  in  NumReq*WordLength  packed data; slice i is `data_i[i*WordLength +: WordLength]`.
- `full_i`  in  1  FIFO full flag from `fifo_ctrl` `full_o`.
- `gnt_o`  out  NumReq  registered one-hot grant, or all zero.
- `wr_o`  out  1  FIFO write strobe, driven to `fifo_ctrl` `wr_i`.
- `w_data_o`  out  WordLength  data to the register file write port.

## Operation
- State: `IDLE` or `GRANT`, plus `owner_q` (index, `$clog2(NumReq)` bits), `last_q` (last owner), and `beats_q` (`$clog2(MaxBurst+1)` bits).
- Accept condition: `acc = (state==GRANT) && req_i[owner_q] && !full_i`.
- `wr_o = acc`. This is combinational, so the write strobe and the accept happen in the same cycle. The FIFO never sees `wr_o=1` while `full_i=1`.
- `w_data_o` is slice `owner_q` of `data_i` while in `GRANT`, and 0 in `IDLE`.
- `gnt_o` is the one-hot encoding of `owner_q` in `GRANT`, and 0 in `IDLE`.
- Arbitration function `pick`:
  - Search `req_i` starting at `(last_q+1) mod NumReq` and wrap around.
  - Return the first set index.
  - The requester that just released is searched last, so it can win again only if no other requester is asserting.
- `IDLE`: if any `req_i` bit is set, `owner_q <= pick`, `beats_q <= 0`, and the next state is `GRANT`. Otherwise stay in `IDLE`.
- `GRANT` with `acc`: `beats_q <= beats_q+1`.
- `GRANT` release conditions:
  - (a) `req_i[owner_q]==0`, or
  - (b) `acc` occurs and `beats_q+1 == MaxBurst`.
- On release:
  - `last_q <= owner_q`.
  - Re-arbitrate in the same cycle using the updated search start `owner_q+1`.
  - If a winner exists, go to `GRANT` with the new owner and `beats_q <= 0`, with no idle bubble.
  - If there is no winner, go to `IDLE`.
- `full_i` high in `GRANT` holds `owner_q` and `beats_q`; the grant is not lost.
- If a requester drops its request while `full_i` is high, release (a) still applies.
- Requester contract: hold `data_i` slice stable while `req_i` is high. A word counts as consumed on the cycle where `gnt_o[i] & req_i[i] & !full_i` is true.
- A producer may sample `gnt_o[i] & !full_i` to advance its data.

## Timing
- Reset values: state `IDLE`, `gnt_o=0`, `wr_o=0`, `w_data_o=0`, `owner_q=0`, `beats_q=0`, `last_q=NumReq-1` (the first search starts at 0).
- Reset mid-burst: `gnt_o=0` in the cycle after the `rst_i` edge. No write may occur while `rst_i` is sampled high.
- Latency from request to first write: the `req_i` edge is sampled at edge N, `gnt_o` is valid after edge N, and the first `wr_o` occurs in cycle N+1 if not full.
- Back-to-back grant handover: the last word of the old owner is in cycle K, and the first word of the new owner is in cycle K+1.
- Sustained throughput: one word per cycle while any request is present and `full_i=0`.

## Configuration
- `FIFO_ARB_BURST_EN` defined: release condition (b) uses `MaxBurst` as stated above.
- `FIFO_ARB_BURST_EN` undefined:
  - `MaxBurst` is ignored and treated as 1, so the grant is released after every accepted word.
  - Round-robin interleaves word by word.
  - `beats_q` may be optimized away.

## Test plan
Configuration for all cases: `NumReq=4`, `WordLength=8`, `MaxBurst=4`.

- **Reset:** `rst_i=1` for 2 cycles with all `req_i=4'b1111` → `gnt_o=0` and `wr_o=0` throughout. The first grant after release is `4'b0001`.
- **Single requester:** `req_i=4'b0100` for 10 words with data 0x20..0x29 and `full_i=0` → `gnt_o=4'b0100` one cycle after the request, then 10 consecutive `wr_o` cycles with `w_data_o` 0x20..0x29 and no bubbles. The same owner is re-granted at each burst boundary.
- **Four requesters:** `req_i=4'b1111` continuously →
  - With `FIFO_ARB_BURST_EN`: grant order 0,1,2,3,0, with 4 writes each and no gaps.
  - Without the macro: the order is the same but with 1 write each.
- **Full stall:** owner 1 has 2 beats done, then `full_i=1` for 5 cycles → `wr_o=0`, `gnt_o=4'b0010` held. Beats 3 and 4 are written after `full_i` falls, then the grant moves to 2.
- **Requester drop:** `req_i[0]` drops after 2 words while `req_i[3]` is high → in the next cycle `gnt_o=4'b1000`, and no extra write is made for requester 0.
- **Mid-burst reset:** `rst_i` pulsed for 1 cycle during the owner-2 burst → `gnt_o=0`, `wr_o=0` in the following cycle. Re-arbitration restarts from index 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NumReq producers.
// Define FIFO_ARB_BURST_EN to keep a grant for up to MaxBurst accepted words.
module fifo_wr_arb #(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned WordLength = 8,
  parameter int unsigned MaxBurst   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq*WordLength-1:0] data_i,
  input  logic                         full_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic                         wr_o,
  output logic [WordLength-1:0]        w_data_o
);

  localparam int unsigned IdxW  = $clog2(NumReq);
  localparam int unsigned BeatW = $clog2(MaxBurst + 1);
`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BurstLen = MaxBurst;
`else
  localparam int unsigned BurstLen = 1;
`endif
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumReq - 1);
  localparam logic [BeatW-1:0] BurstEnd = BeatW'(BurstLen);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [BeatW-1:0]  beats_q, beats_d;

  logic              acc;
  logic [BeatW-1:0]  beats_inc;
  logic              release_gnt;
  logic [IdxW-1:0]   search_start;
  logic [IdxW-1:0]   pick_idx;
  logic [WordLength-1:0] data_arr [NumReq];

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + IdxW'(1);
  endfunction

  // First set request at or after start, wrapping; start itself is the previous owner + 1.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] req,
                                              input logic [IdxW-1:0]   start);
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] win;
    logic            found;
    cand  = start;
    win   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = next_idx(cand);
    end
    return win;
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      data_arr[k] = data_i[k*WordLength +: WordLength];
    end
  end

  // Writes are suppressed while reset is being sampled.
  always_comb begin
    acc      = (state_q == StGrant) && req_i[owner_q] && !full_i && !rst_i;
    wr_o     = acc;
    gnt_o    = '0;
    w_data_o = '0;
    if (state_q == StGrant) begin
      gnt_o[owner_q] = 1'b1;
      w_data_o       = data_arr[owner_q];
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    beats_d      = beats_q;
    beats_inc    = beats_q + BeatW'(1);
    release_gnt  = !req_i[owner_q] || (acc && (beats_inc == BurstEnd));
    search_start = next_idx((state_q == StGrant) ? owner_q : last_q);
    pick_idx     = rr_pick(req_i, search_start);

    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StGrant;
          owner_d = pick_idx;
          beats_d = '0;
        end
      end
      StGrant: begin
        if (acc) begin
          beats_d = beats_inc;
        end
        // Hand over in the same cycle so the next owner writes without a bubble.
        if (release_gnt) begin
          last_d  = owner_q;
          beats_d = '0;
          if (|req_i) begin
            owner_d = pick_idx;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= LastIdx;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb; expected write order is hand-derived per scenario
// for both the burst (FIFO_ARB_BURST_EN) and word-by-word builds.
module tb_fifo_wr_arb;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic        full_i;
  logic [3:0]  gnt_o;
  logic        wr_o;
  logic [7:0]  w_data_o;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cnt [4];
  logic [7:0]  dat [4];
  exp_t        sb [$];

  fifo_wr_arb #(
    .NumReq     (4),
    .WordLength (8),
    .MaxBurst   (4)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .data_i   (data_i),
    .full_i   (full_i),
    .gnt_o    (gnt_o),
    .wr_o     (wr_o),
    .w_data_o (w_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < 4; r++) begin
      req_i[r]         = (cnt[r] != 0);
      data_i[r*8 +: 8] = dat[r];
    end
  endtask

  task automatic load(input int r, input int n, input logic [7:0] base);
    cnt[r] = n;
    dat[r] = base;
    drive();
  endtask

  task automatic push(input int r, input logic [7:0] d);
    exp_t e;
    e.idx  = 2'(r);
    e.data = d;
    sb.push_back(e);
  endtask

  // One clock: note which producers were consumed, then advance them after the edge.
  task automatic tick();
    logic [3:0] cons;
    @(negedge clk);
    cons = gnt_o & req_i & {4{~full_i & ~rst_i}};
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin
      if (cons[r]) begin
        dat[r] = dat[r] + 8'd1;
        cnt[r] = cnt[r] - 1;
      end
    end
    drive();
    #1;
  endtask

  task automatic reset_seq(input int n);
    rst_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check("reset_gnt", 32'(gnt_o), 32'h0);
      check("reset_wr", 32'(wr_o), 32'h0);
    end
    rst_i = 1'b0;
  endtask

  task automatic drain(input int lim);
    int k;
    bit busy;
    k = 0;
    busy = 1'b1;
    while (busy && k < lim) begin
      busy = (sb.size() != 0);
      for (int r = 0; r < 4; r++) if (cnt[r] != 0) busy = 1'b1;
      if (busy) tick();
      k++;
    end
    check("drain_sb_empty", 32'(sb.size()), 32'h0);
    tick();
    tick();
  endtask

  // Monitor: every write strobe pops one expected (owner, data) pair.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] eg;
    if (wr_o === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: gnt %b data %0h, expected no write (t=%0t)",
                 gnt_o, w_data_o, $time);
      end else begin
        e  = sb.pop_front();
        eg = 4'b0001 << e.idx;
        if (gnt_o !== eg || w_data_o !== e.data) begin
          n_fail++;
          $display("FAIL write_word: gnt %b data %0h, expected gnt %b data %0h (t=%0t)",
                   gnt_o, w_data_o, eg, e.data, $time);
        end
      end
    end else if (wr_o !== 1'b0 && rst_i === 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wr_known: got %b, expected 0 or 1 (t=%0t)", wr_o, $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_wr;
    logic [3:0] exp_gnt;
    rst_i  = 1'b1;
    full_i = 1'b0;
    req_i  = '0;
    data_i = '0;
    for (int r = 0; r < 4; r++) begin
      cnt[r] = 0;
      dat[r] = '0;
    end

    // Reset held with all requests asserted; first grant goes to 0.
    for (int r = 0; r < 4; r++) load(r, 1, 8'hA0 + 8'(r));
    for (int r = 0; r < 4; r++) push(r, 8'hA0 + 8'(r));
    reset_seq(2);
    tick();
    check("first_grant", 32'(gnt_o), 32'h1);
    drain(40);

    // Single requester, 10 contiguous words.
    reset_seq(1);
    load(2, 10, 8'h20);
    for (int k = 0; k < 10; k++) push(2, 8'h20 + 8'(k));
    check("single_gnt_c0", 32'(gnt_o), 32'h0);
    tick();
    check("single_gnt_c1", 32'(gnt_o), 32'h4);
    repeat (9) tick();
    check("single_left_1", 32'(sb.size()), 32'd1);
    tick();
    check("single_left_0", 32'(sb.size()), 32'd0);
    drain(20);

    // Four requesters continuously asserting.
    reset_seq(1);
    for (int r = 0; r < 4; r++) load(r, 8, 8'h40 + 8'(r * 16));
`ifdef FIFO_ARB_BURST_EN
    for (int rd = 0; rd < 2; rd++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) push(r, 8'h40 + 8'(r * 16 + rd * 4 + k));
`else
    for (int k = 0; k < 8; k++)
      for (int r = 0; r < 4; r++) push(r, 8'h40 + 8'(r * 16 + k));
`endif
    repeat (32) tick();
    check("four_left_1", 32'(sb.size()), 32'd1);
    tick();
    check("four_left_0", 32'(sb.size()), 32'd0);
    drain(20);

    // FIFO full stall on owner 1 after two words.
    reset_seq(1);
    load(1, 4, 8'h60);
    load(2, 2, 8'h70);
`ifdef FIFO_ARB_BURST_EN
    for (int k = 0; k < 4; k++) push(1, 8'h60 + 8'(k));
    push(2, 8'h70);
    push(2, 8'h71);
    exp_gnt = 4'b0100;
`else
    push(1, 8'h60); push(2, 8'h70); push(1, 8'h61);
    push(2, 8'h71); push(1, 8'h62); push(1, 8'h63);
    exp_gnt = 4'b0010;
`endif
    repeat (3) tick();
    full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_gnt", 32'(gnt_o), 32'h2);
      check("stall_wr", 32'(wr_o), 32'h0);
      tick();
    end
    full_i = 1'b0;
    repeat (2) tick();
    check("stall_gnt_c10", 32'(gnt_o), 32'(exp_gnt));
    repeat (2) tick();
    check("stall_left_0", 32'(sb.size()), 32'd0);
    drain(20);

    // Requester 0 drops after two words while 3 waits.
    reset_seq(1);
    load(0, 2, 8'hA0);
    load(3, 2, 8'hB0);
`ifdef FIFO_ARB_BURST_EN
    push(0, 8'hA0); push(0, 8'hA1); push(3, 8'hB0); push(3, 8'hB1);
    exp_wr = 1'b0;
`else
    push(0, 8'hA0); push(3, 8'hB0); push(0, 8'hA1); push(3, 8'hB1);
    exp_wr = 1'b1;
`endif
    repeat (3) tick();
    check("drop_gnt_c3", 32'(gnt_o), 32'h1);
    check("drop_wr_c3", 32'(wr_o), 32'(exp_wr));
    tick();
    check("drop_gnt_c4", 32'(gnt_o), 32'h8);
    drain(20);

    // Reset pulse in the middle of owner 2's burst; search restarts from index 0.
    reset_seq(1);
    load(2, 6, 8'h80);
    push(2, 8'h80);
    push(2, 8'h81);
`ifdef FIFO_ARB_BURST_EN
    for (int k = 2; k < 6; k++) push(2, 8'h80 + 8'(k));
    push(3, 8'h90);
`else
    push(2, 8'h82); push(3, 8'h90); push(2, 8'h83);
    push(2, 8'h84); push(2, 8'h85);
`endif
    repeat (3) tick();
    rst_i = 1'b1;
    load(3, 1, 8'h90);
    #1;
    check("midrst_wr_in_rst", 32'(wr_o), 32'h0);
    tick();
    rst_i = 1'b0;
    #1;
    check("midrst_gnt_after", 32'(gnt_o), 32'h0);
    check("midrst_wr_after", 32'(wr_o), 32'h0);
    tick();
    check("midrst_regrant", 32'(gnt_o), 32'h4);
    drain(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
